// File: rtl/ex_stage_pipelined.sv
// Execute stage: forwarding, ALU control, ALU, branch-target adder, destination select,
// and a WIDTH-cycle shift-add multiplier. Owns the EX/MEM register; stalls upstream while multiplying.
module ex_stage_pipelined #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned RADDR_W = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               flush,
  input  logic [WIDTH-1:0]   pc_next,
  input  logic [WIDTH-1:0]   rs_data,
  input  logic [WIDTH-1:0]   rt_data,
  input  logic [WIDTH-1:0]   imm,
  input  logic [RADDR_W-1:0] rt_addr,
  input  logic [RADDR_W-1:0] rd_addr,
  input  logic               alu_src,
  input  logic [1:0]         alu_op,
  input  logic               reg_dst,
  input  logic [1:0]         fwd_a,
  input  logic [1:0]         fwd_b,
  input  logic [WIDTH-1:0]   fwd_mem,
  input  logic [WIDTH-1:0]   fwd_wb,
  output logic               stall,
  output logic               out_valid,
  output logic [WIDTH-1:0]   alu_result,
  output logic               zero,
  output logic [WIDTH-1:0]   branch_tgt,
  output logic [WIDTH-1:0]   store_data,
  output logic [RADDR_W-1:0] dest_reg
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] FN_ADD = 3'b000;
  localparam logic [2:0] FN_SUB = 3'b001;
  localparam logic [2:0] FN_AND = 3'b010;
  localparam logic [2:0] FN_OR  = 3'b011;
  localparam logic [2:0] FN_SLT = 3'b100;
  localparam logic [2:0] FN_MUL = 3'b101;
  localparam logic [2:0] FN_XOR = 3'b110;
  localparam logic [2:0] FN_NOR = 3'b111;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   acc;

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   fwd_rt;
  logic [WIDTH-1:0]   op_b;
  logic [2:0]         alu_fn;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   tgt;
  logic [RADDR_W-1:0] dest;
  logic [WIDTH-1:0]   acc_next;

  assign stall = (state == BUSY);

  // Operand forwarding and B-source select
  always_comb begin
    op_a   = rs_data;
    fwd_rt = rt_data;
    case (fwd_a)
      2'b01:   op_a = fwd_mem;
      2'b10:   op_a = fwd_wb;
      default: op_a = rs_data;
    endcase
    case (fwd_b)
      2'b01:   fwd_rt = fwd_mem;
      2'b10:   fwd_rt = fwd_wb;
      default: fwd_rt = rt_data;
    endcase
    op_b = alu_src ? imm : fwd_rt;
  end

  // ALU control and single-cycle ALU
  always_comb begin
    alu_fn  = FN_ADD;
    alu_res = '0;
    case (alu_op)
      2'b01:   alu_fn = FN_SUB;
      2'b10:   alu_fn = imm[2:0];
      default: alu_fn = FN_ADD;
    endcase
    case (alu_fn)
      FN_ADD:  alu_res = op_a + op_b;
      FN_SUB:  alu_res = op_a - op_b;
      FN_AND:  alu_res = op_a & op_b;
      FN_OR:   alu_res = op_a | op_b;
      FN_SLT:  alu_res = WIDTH'($signed(op_a) < $signed(op_b));
      FN_XOR:  alu_res = op_a ^ op_b;
      FN_NOR:  alu_res = ~(op_a | op_b);
      default: alu_res = '0;
    endcase
  end

  assign tgt      = pc_next + {imm[WIDTH-2:0], 1'b0};
  assign dest     = reg_dst ? rd_addr : rt_addr;
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  // Multiplier FSM and EX/MEM register; flush overrides accept and completion
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      out_valid  <= 1'b0;
      alu_result <= '0;
      zero       <= 1'b0;
      branch_tgt <= '0;
      store_data <= '0;
      dest_reg   <= '0;
    end else begin
      out_valid <= 1'b0;
      if (flush) begin
        state <= IDLE;
        count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (in_valid) begin
              branch_tgt <= tgt;
              store_data <= fwd_rt;
              dest_reg   <= dest;
              if (alu_fn == FN_MUL) begin
                mcand  <= op_a;
                mplier <= op_b;
                acc    <= '0;
                count  <= CNT_W'(WIDTH);
                state  <= BUSY;
              end else begin
                alu_result <= alu_res;
                zero       <= (alu_res == '0);
                out_valid  <= 1'b1;
              end
            end
          end
          BUSY: begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
              alu_result <= acc_next;
              zero       <= (acc_next == '0);
              out_valid  <= 1'b1;
              state      <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_pipelined.sv
// Directed bench for ex_stage_pipelined: hand-computed vectors checked with immediate assertions.
module tb_ex_stage_pipelined;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        flush;
  logic [15:0] pc_next;
  logic [15:0] rs_data;
  logic [15:0] rt_data;
  logic [15:0] imm;
  logic [2:0]  rt_addr;
  logic [2:0]  rd_addr;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic        reg_dst;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [15:0] fwd_mem;
  logic [15:0] fwd_wb;
  logic        stall;
  logic        out_valid;
  logic [15:0] alu_result;
  logic        zero;
  logic [15:0] branch_tgt;
  logic [15:0] store_data;
  logic [2:0]  dest_reg;

  int vectors;
  int miscompares;
  int hits;

  ex_stage_pipelined #(.WIDTH(16), .RADDR_W(3)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .flush(flush),
    .pc_next(pc_next), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .rt_addr(rt_addr), .rd_addr(rd_addr), .alu_src(alu_src), .alu_op(alu_op),
    .reg_dst(reg_dst), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_mem(fwd_mem),
    .fwd_wb(fwd_wb), .stall(stall), .out_valid(out_valid), .alu_result(alu_result),
    .zero(zero), .branch_tgt(branch_tgt), .store_data(store_data), .dest_reg(dest_reg)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input logic [1:0] op, input logic src, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] im);
    alu_op  = op;
    alu_src = src;
    rs_data = a;
    rt_data = b;
    imm     = im;
    fwd_a   = 2'b00;
    fwd_b   = 2'b00;
  endtask

  initial begin
    vectors = 0; miscompares = 0; hits = 0;
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0;
    pc_next = '0; rs_data = '0; rt_data = '0; imm = '0;
    rt_addr = '0; rd_addr = '0; alu_src = 1'b0; alu_op = 2'b00; reg_dst = 1'b0;
    fwd_a = 2'b00; fwd_b = 2'b00; fwd_mem = '0; fwd_wb = '0;

    tick(); tick();
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_result", 32'(alu_result), 32'h0);
    chk("rst_zero", 32'(zero), 32'h0);
    chk("rst_tgt", 32'(branch_tgt), 32'h0);
    chk("rst_store", 32'(store_data), 32'h0);
    chk("rst_dest", 32'(dest_reg), 32'h0);
    reset = 1'b1;

    // forwarded A from MEM plus immediate
    set_op(2'b00, 1'b1, 16'h1111, 16'h5555, 16'h0002);
    fwd_a = 2'b01; fwd_mem = 16'h0030; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("fwd_mem_add", 32'(alu_result), 32'h0032);
    chk("fwd_mem_valid", 32'(out_valid), 32'h1);
    chk("fwd_mem_store", 32'(store_data), 32'h5555);
    chk("fwd_mem_tgt", 32'(branch_tgt), 32'h0004);

    // branch target and rd destination
    set_op(2'b00, 1'b1, 16'h0001, 16'h0000, 16'h0004);
    pc_next = 16'h0010; reg_dst = 1'b1; rd_addr = 3'd5; rt_addr = 3'd2; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("br_tgt", 32'(branch_tgt), 32'h0018);
    chk("br_dest", 32'(dest_reg), 32'h5);
    chk("br_result", 32'(alu_result), 32'h0005);
    tick();
    chk("idle_valid", 32'(out_valid), 32'h0);
    chk("idle_hold", 32'(alu_result), 32'h0005);

    // wrap, slt, sub, xor with WB forwarding, nor, alu_op 11
    set_op(2'b00, 1'b0, 16'hFFFF, 16'h0001, 16'h0000);
    reg_dst = 1'b0; rt_addr = 3'd3; in_valid = 1'b1;
    tick();
    chk("add_wrap", 32'(alu_result), 32'h0000);
    chk("add_wrap_zero", 32'(zero), 32'h1);
    chk("rt_dest", 32'(dest_reg), 32'h3);
    set_op(2'b10, 1'b0, 16'hFFFF, 16'h0001, 16'h0004);
    tick();
    chk("slt", 32'(alu_result), 32'h0001);
    chk("slt_zero", 32'(zero), 32'h0);
    set_op(2'b01, 1'b0, 16'h0003, 16'h0005, 16'h0000);
    tick();
    chk("sub", 32'(alu_result), 32'hFFFE);
    set_op(2'b10, 1'b0, 16'h0FF0, 16'hFFFF, 16'h0006);
    fwd_b = 2'b10; fwd_wb = 16'h00F0;
    tick();
    chk("xor_fwd_wb", 32'(alu_result), 32'h0F00);
    chk("xor_store", 32'(store_data), 32'h00F0);
    set_op(2'b10, 1'b0, 16'h00FF, 16'h0F00, 16'h0007);
    tick();
    chk("nor", 32'(alu_result), 32'hF000);
    set_op(2'b11, 1'b1, 16'h0100, 16'h0000, 16'h0023);
    tick();
    chk("op11_add", 32'(alu_result), 32'h0123);

    // 7*9 with an add held behind it
    set_op(2'b10, 1'b0, 16'h0007, 16'h0009, 16'h0005);
    tick();
    chk("mul_accept_stall", 32'(stall), 32'h1);
    chk("mul_accept_valid", 32'(out_valid), 32'h0);
    set_op(2'b00, 1'b0, 16'h1234, 16'h0001, 16'h0000);
    hits = 0;
    repeat (15) begin
      tick();
      if (stall && !out_valid) hits++;
    end
    chk("mul_busy_cycles", 32'(hits), 32'd15);
    tick();
    chk("mul_valid", 32'(out_valid), 32'h1);
    chk("mul_result", 32'(alu_result), 32'h003F);
    chk("mul_stall_drop", 32'(stall), 32'h0);
    tick(); in_valid = 1'b0;
    chk("b2b_valid", 32'(out_valid), 32'h1);
    chk("b2b_result", 32'(alu_result), 32'h1235);

    // multiply that wraps to zero
    set_op(2'b10, 1'b0, 16'h8000, 16'h0002, 16'h0005);
    in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    repeat (16) tick();
    chk("mulz_valid", 32'(out_valid), 32'h1);
    chk("mulz_result", 32'(alu_result), 32'h0000);
    chk("mulz_zero", 32'(zero), 32'h1);

    // flush on the 8th busy cycle, then an add
    set_op(2'b10, 1'b0, 16'h0003, 16'h0005, 16'h0005);
    in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    repeat (7) tick();
    flush = 1'b1;
    tick(); flush = 1'b0;
    chk("flush_stall", 32'(stall), 32'h0);
    chk("flush_valid", 32'(out_valid), 32'h0);
    set_op(2'b00, 1'b0, 16'h0003, 16'h0004, 16'h0000);
    in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("post_flush_add", 32'(alu_result), 32'h0007);
    hits = 0;
    repeat (10) begin
      tick();
      if (out_valid) hits++;
    end
    chk("flush_no_result", 32'(hits), 32'd0);
    set_op(2'b00, 1'b0, 16'h0001, 16'h0001, 16'h0000);
    in_valid = 1'b1; flush = 1'b1;
    tick(); in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_valid", 32'(out_valid), 32'h0);
    chk("flush_idle_hold", 32'(alu_result), 32'h0007);

    // reset while busy with count at 5
    set_op(2'b10, 1'b0, 16'h0007, 16'h0009, 16'h0005);
    in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    repeat (11) tick();
    reset = 1'b0;
    #1;
    chk("mrst_stall", 32'(stall), 32'h0);
    chk("mrst_valid", 32'(out_valid), 32'h0);
    chk("mrst_result", 32'(alu_result), 32'h0);
    chk("mrst_zero", 32'(zero), 32'h0);
    chk("mrst_tgt", 32'(branch_tgt), 32'h0);
    chk("mrst_store", 32'(store_data), 32'h0);
    chk("mrst_dest", 32'(dest_reg), 32'h0);
    tick(); reset = 1'b1;
    hits = 0;
    repeat (20) begin
      tick();
      if (out_valid || stall) hits++;
    end
    chk("mrst_no_result", 32'(hits), 32'd0);
    set_op(2'b00, 1'b1, 16'h0002, 16'h0000, 16'h0003);
    in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("mrst_add_valid", 32'(out_valid), 32'h1);
    chk("mrst_add_result", 32'(alu_result), 32'h0005);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
